// File: rtl/tvp_frame_sampler_if.sv
// Memory write bus between the frame sampler and the SDRAM controller.
// The sampler issues zero-latency write requests; the controller only
// back-pressures through busy.
interface tvp_frame_sampler_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              in_valid;

    modport master (
        output addr,
        output rw,
        output data_in,
        output in_valid,
        input  busy
    );

    modport slave (
        input  addr,
        input  rw,
        input  data_in,
        input  in_valid,
        output busy
    );
endinterface

// File: rtl/tvp_frame_sampler.sv
// TVP frame sampler: brings the TVP pixel clock and VSYNC into the system
// clock domain, captures a programmed number of RGB pixels starting at the
// first VSYNC after arming, buffers them in a small FIFO and writes them to
// consecutive memory words starting at a programmed base address.
module tvp_frame_sampler #(
    parameter int COLOR_W = 8,
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 32,
    parameter int FIFO_AW = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [COLOR_W-1:0]   r,
    input  logic [COLOR_W-1:0]   g,
    input  logic [COLOR_W-1:0]   b,
    input  logic                 sample_clock,
    input  logic                 vsync,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W-1:0]    length,
    tvp_frame_sampler_if.master  mem,
    output logic                 capturing,
    output logic                 done,
    output logic [7:0]           drop_cnt,
    output logic [3:0]           leds
);
    localparam int PIX_W = 3 * COLOR_W;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [ADDR_W-1:0]  ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0]   PTR_ONE  = {{FIFO_AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_VSYNC = 3'd1,
        ST_CAPTURE    = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    // Place a pixel in the top bits of a memory word, zero-filling below it.
    function automatic logic [DATA_W-1:0] pad_pixel(input logic [PIX_W-1:0] pix);
        logic [DATA_W-1:0] word;
        word = {DATA_W{1'b0}};
        word[DATA_W-1 -: PIX_W] = pix;
        return word;
    endfunction

    state_t state_r, state_next_s;

    // [0],[1] are the synchroniser stages, [2] holds the previous synced value.
    logic [2:0] pclk_sync_r;
    logic [2:0] vsync_sync_r;
    logic       pix_edge_s;
    logic       vsync_edge_s;

    logic [PIX_W-1:0]  fifo_mem_r [0:DEPTH-1];
    logic [FIFO_AW:0]  wr_ptr_r;
    logic [FIFO_AW:0]  rd_ptr_r;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic [PIX_W-1:0]  fifo_head_s;

    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] accepted_r;
    logic [ADDR_W-1:0] wr_idx_r;
    logic [7:0]        drop_cnt_r;
    logic [7:0]        drop_cnt_next_s;

    logic start_s;
    logic push_s;
    logic drop_s;
    logic pop_s;

    logic wait_flag_r;
    logic cap_flag_r;
    logic done_flag_r;
    logic drop_flag_r;

    assign pix_edge_s   = pclk_sync_r[1]  & ~pclk_sync_r[2];
    assign vsync_edge_s = vsync_sync_r[1] & ~vsync_sync_r[2];

    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[FIFO_AW] != rd_ptr_r[FIFO_AW]) &&
                          (wr_ptr_r[FIFO_AW-1:0] == rd_ptr_r[FIFO_AW-1:0]);
    assign fifo_head_s  = fifo_mem_r[rd_ptr_r[FIFO_AW-1:0]];

    // A write is accepted in the cycle it is requested, so a request is a pop.
    assign pop_s = ~fifo_empty_s & ~mem.busy & ~abort;

    assign mem.in_valid = pop_s;
    assign mem.rw       = pop_s;
    assign mem.addr     = pop_s ? (base_r + wr_idx_r) : {ADDR_W{1'b0}};
    assign mem.data_in  = pop_s ? pad_pixel(fifo_head_s) : {DATA_W{1'b0}};

    assign capturing = wait_flag_r | cap_flag_r;
    assign done      = done_flag_r;
    assign drop_cnt  = drop_cnt_r;
    assign leds      = {drop_flag_r, done_flag_r, cap_flag_r, wait_flag_r};

    // Two-flop synchronisers plus history flop for the asynchronous TVP strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pclk_sync_r  <= 3'b000;
            vsync_sync_r <= 3'b000;
        end else begin
            pclk_sync_r  <= {pclk_sync_r[1:0], sample_clock};
            vsync_sync_r <= {vsync_sync_r[1:0], vsync};
        end
    end

    // Capture state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and per-cycle capture decisions; abort overrides all.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        push_s       = 1'b0;
        drop_s       = 1'b0;
        if (abort) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        start_s = 1'b1;
                        if (length == {ADDR_W{1'b0}}) begin
                            state_next_s = ST_DONE;
                        end else begin
                            state_next_s = ST_WAIT_VSYNC;
                        end
                    end else begin
                        state_next_s = state_r;
                    end
                end
                ST_WAIT_VSYNC: begin
                    // A pixel edge coinciding with the VSYNC edge is not captured.
                    if (vsync_edge_s) begin
                        state_next_s = ST_CAPTURE;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                ST_CAPTURE: begin
                    if (pix_edge_s) begin
                        if (!fifo_full_s || pop_s) begin
                            push_s = 1'b1;
                            if ((accepted_r + ADDR_ONE) == len_r) begin
                                state_next_s = ST_DRAIN;
                            end else begin
                                state_next_s = state_r;
                            end
                        end else begin
                            drop_s       = 1'b1;
                            state_next_s = state_r;
                        end
                    end else begin
                        state_next_s = state_r;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty_s && !pop_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Saturating drop counter update; cleared when a new capture is armed.
    always_comb begin
        drop_cnt_next_s = drop_cnt_r;
        if (start_s) begin
            drop_cnt_next_s = 8'd0;
        end else if (drop_s && (drop_cnt_r != 8'd255)) begin
            drop_cnt_next_s = drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_next_s = drop_cnt_r;
        end
    end

    // Capture bookkeeping: programmed window, accepted pixels, write index, drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r     <= {ADDR_W{1'b0}};
            len_r      <= {ADDR_W{1'b0}};
            accepted_r <= {ADDR_W{1'b0}};
            wr_idx_r   <= {ADDR_W{1'b0}};
            drop_cnt_r <= 8'd0;
        end else begin
            drop_cnt_r <= drop_cnt_next_s;
            if (start_s) begin
                base_r     <= base_addr;
                len_r      <= length;
                accepted_r <= {ADDR_W{1'b0}};
                wr_idx_r   <= {ADDR_W{1'b0}};
            end else begin
                if (push_s) begin
                    accepted_r <= accepted_r + ADDR_ONE;
                end
                if (pop_s) begin
                    wr_idx_r <= wr_idx_r + ADDR_ONE;
                end
            end
        end
    end

    // FIFO pointers; abort flushes whatever is queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(FIFO_AW+1){1'b0}};
            rd_ptr_r <= {(FIFO_AW+1){1'b0}};
        end else if (abort) begin
            wr_ptr_r <= {(FIFO_AW+1){1'b0}};
            rd_ptr_r <= {(FIFO_AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // FIFO storage; pixel data is taken straight from the pins on the edge cycle.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[FIFO_AW-1:0]] <= {r, g, b};
        end
    end

    // Status flags registered from the next state so they track the FSM exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_flag_r <= 1'b0;
            cap_flag_r  <= 1'b0;
            done_flag_r <= 1'b0;
            drop_flag_r <= 1'b0;
        end else begin
            wait_flag_r <= (state_next_s == ST_WAIT_VSYNC);
            cap_flag_r  <= (state_next_s == ST_CAPTURE);
            done_flag_r <= (state_next_s == ST_DONE);
            drop_flag_r <= (drop_cnt_next_s != 8'd0);
        end
    end
endmodule

// File: tb/tb_tvp_frame_sampler.sv
// Self-checking bench for tvp_frame_sampler: scenario tasks drive the TVP
// pins and memory busy, a negedge monitor records every memory write, and
// each task compares the recorded writes and status against expectations
// built from the capture rules (first N accepted pixels, contiguous wrapping
// addresses, pixel MSB-aligned in the word).
module tb_tvp_frame_sampler;
    localparam int COLOR_W = 8;
    localparam int ADDR_W  = 23;
    localparam int DATA_W  = 32;
    localparam int FIFO_AW = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [COLOR_W-1:0] r = 8'h00;
    logic [COLOR_W-1:0] g = 8'h00;
    logic [COLOR_W-1:0] b = 8'h00;
    logic               sample_clock = 1'b0;
    logic               vsync = 1'b0;
    logic               arm = 1'b0;
    logic               abort = 1'b0;
    logic               busy = 1'b0;
    logic [ADDR_W-1:0]  base_addr = 23'd0;
    logic [ADDR_W-1:0]  length = 23'd0;
    logic               capturing;
    logic               done;
    logic [7:0]         drop_cnt;
    logic [3:0]         leds;

    bit rand_busy = 1'b0;
    int total = 0;
    int bad = 0;
    int idle_bad = 0;
    int rw_bad = 0;

    logic [ADDR_W-1:0] got_addr [$];
    logic [DATA_W-1:0] got_data [$];
    logic [ADDR_W-1:0] exp_addr [$];
    logic [DATA_W-1:0] exp_data [$];

    tvp_frame_sampler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();
    assign mem_if.busy = busy;

    tvp_frame_sampler #(
        .COLOR_W(COLOR_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_AW(FIFO_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .r(r), .g(g), .b(b),
        .sample_clock(sample_clock), .vsync(vsync), .arm(arm), .abort(abort),
        .base_addr(base_addr), .length(length), .mem(mem_if.master),
        .capturing(capturing), .done(done), .drop_cnt(drop_cnt), .leds(leds)
    );

    always #5 clk = ~clk;

    // Write monitor: log accepted writes and note bus-rule violations.
    always @(negedge clk) begin
        if (mem_if.in_valid === 1'b1) begin
            got_addr.push_back(mem_if.addr);
            got_data.push_back(mem_if.data_in);
        end else if (mem_if.addr !== 23'd0 || mem_if.data_in !== 32'd0) begin
            idle_bad++;
        end
        if (mem_if.rw !== mem_if.in_valid) rw_bad++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got_addr.delete(); got_data.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    task automatic arm_cmd(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len);
        base_addr = base;
        length    = len;
        arm       = 1'b1;
        tick();
        arm       = 1'b0;
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        repeat (4) tick();
        vsync = 1'b0;
        repeat (4) tick();
    endtask

    task automatic send_pixel(input logic [23:0] pix);
        {r, g, b} = pix;
        sample_clock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (rand_busy) busy = 1'($urandom_range(0, 1));
            tick();
        end
        sample_clock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rand_busy) busy = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] base, input int idx, input logic [23:0] pix);
        logic [ADDR_W-1:0] a;
        a = base + ADDR_W'(idx);
        exp_addr.push_back(a);
        exp_data.push_back({pix, 8'h00});
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) return i;
        end
        if (got_addr.size() != exp_addr.size()) return n;
        return -1;
    endfunction

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        total++;
        if ({mem_if.in_valid, mem_if.rw, mem_if.addr, mem_if.data_in, capturing, done, drop_cnt, leds} !== 72'd0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b addr=%h data=%h cap=%b done=%b drop=%0d leds=%b, required all 0",
                     mem_if.in_valid, mem_if.addr, mem_if.data_in, capturing, done, drop_cnt, leds);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [23:0] pix [6];
        bit ok;
        int d;
        clear_log();
        arm_cmd(23'h100, 23'd4);
        total++;
        if (leds !== 4'b0001 || capturing !== 1'b1) begin
            bad++; $display("FAIL basic_wait_leds: got leds=%b cap=%b, required 0001/1", leds, capturing);
        end
        vsync_pulse();
        total++;
        if (leds !== 4'b0010) begin
            bad++; $display("FAIL basic_capture_leds: got %b, required 0010", leds);
        end
        for (int i = 0; i < 6; i++) begin
            pix[i] = 24'($urandom);
            if (i < 4) expect_write(23'h100, i, pix[i]);
            send_pixel(pix[i]);
        end
        wait_done(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_done: got done=%b, required 1", done); end
        repeat (3) tick();
        d = first_diff();
        total++;
        if (d != -1) begin
            bad++; $display("FAIL basic_writes: first difference at write %0d, got %0d writes, required %0d", d, got_addr.size(), exp_addr.size());
        end
        total++;
        if (drop_cnt !== 8'd0 || leds !== 4'b0100) begin
            bad++; $display("FAIL basic_status: got drop=%0d leds=%b, required 0/0100", drop_cnt, leds);
        end
    endtask

    task automatic test_wait_vsync();
        logic [23:0] pix;
        bit ok;
        int d;
        clear_log();
        arm_cmd(23'h200, 23'd2);
        send_pixel(24'h123456);
        send_pixel(24'h654321);
        total++;
        if (got_addr.size() != 0 || leds !== 4'b0001) begin
            bad++; $display("FAIL prevsync_no_write: got %0d writes leds=%b, required 0/0001", got_addr.size(), leds);
        end
        // VSYNC and pixel clock rise together: that pixel must be skipped.
        {r, g, b} = 24'hDEAD01;
        vsync = 1'b1;
        sample_clock = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        sample_clock = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            pix = 24'($urandom);
            expect_write(23'h200, i, pix);
            send_pixel(pix);
        end
        wait_done(ok);
        repeat (3) tick();
        d = first_diff();
        total++;
        if (!ok || d != -1) begin
            bad++; $display("FAIL coincident_skip: done=%b diff at %0d, got %0d writes, required %0d", ok, d, got_addr.size(), exp_addr.size());
        end
    endtask

    task automatic test_busy_stall();
        logic [23:0] pix;
        bit ok;
        int d;
        clear_log();
        busy = 1'b1;
        arm_cmd(23'h300, 23'd16);
        vsync_pulse();
        for (int i = 0; i < 12; i++) begin
            pix = 24'($urandom);
            if (i < 8) expect_write(23'h300, i, pix);
            send_pixel(pix);
        end
        total++;
        if (got_addr.size() != 0 || drop_cnt !== 8'd4 || done !== 1'b0 || leds !== 4'b1010) begin
            bad++; $display("FAIL stall_full: got writes=%0d drop=%0d done=%b leds=%b, required 0/4/0/1010", got_addr.size(), drop_cnt, done, leds);
        end
        busy = 1'b0;
        for (int i = 8; i < 15; i++) begin
            pix = 24'($urandom);
            expect_write(23'h300, i, pix);
            send_pixel(pix);
        end
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL stall_early_done: got done=%b after 15 accepted, required 0", done);
        end
        pix = 24'($urandom);
        expect_write(23'h300, 15, pix);
        send_pixel(pix);
        wait_done(ok);
        repeat (3) tick();
        d = first_diff();
        total++;
        if (!ok || d != -1) begin
            bad++; $display("FAIL stall_writes: done=%b diff at %0d, got %0d writes, required %0d", ok, d, got_addr.size(), exp_addr.size());
        end
        total++;
        if (drop_cnt !== 8'd4 || leds !== 4'b1100) begin
            bad++; $display("FAIL stall_status: got drop=%0d leds=%b, required 4/1100", drop_cnt, leds);
        end
    endtask

    task automatic test_wrap();
        logic [23:0] pix;
        bit ok;
        int d;
        clear_log();
        arm_cmd(23'h7FFFFE, 23'd4);
        vsync_pulse();
        for (int i = 0; i < 4; i++) begin
            pix = 24'($urandom);
            expect_write(23'h7FFFFE, i, pix);
            send_pixel(pix);
        end
        wait_done(ok);
        repeat (3) tick();
        d = first_diff();
        total++;
        if (!ok || d != -1) begin
            bad++; $display("FAIL wrap_writes: done=%b diff at %0d, got %0d writes, required %0d", ok, d, got_addr.size(), exp_addr.size());
        end
        total++;
        if (drop_cnt !== 8'd0) begin
            bad++; $display("FAIL wrap_drop_cleared: got %0d, required 0", drop_cnt);
        end
    endtask

    task automatic test_abort();
        logic [23:0] pix;
        bit ok;
        int d;
        clear_log();
        busy = 1'b1;
        arm_cmd(23'h400, 23'd8);
        vsync_pulse();
        for (int i = 0; i < 3; i++) send_pixel(24'($urandom));
        busy  = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        total++;
        if (mem_if.in_valid !== 1'b0) begin
            bad++; $display("FAIL abort_valid: got in_valid=%b during abort, required 0", mem_if.in_valid);
        end
        @(posedge clk);
        #1;
        abort = 1'b0;
        repeat (4) tick();
        total++;
        if (got_addr.size() != 0 || capturing !== 1'b0 || leds !== 4'b0000 || mem_if.in_valid !== 1'b0) begin
            bad++; $display("FAIL abort_flush: got writes=%0d cap=%b leds=%b valid=%b, required 0/0/0000/0",
                            got_addr.size(), capturing, leds, mem_if.in_valid);
        end
        arm_cmd(23'h400, 23'd2);
        vsync_pulse();
        for (int i = 0; i < 2; i++) begin
            pix = 24'($urandom);
            expect_write(23'h400, i, pix);
            send_pixel(pix);
        end
        wait_done(ok);
        repeat (3) tick();
        d = first_diff();
        total++;
        if (!ok || d != -1) begin
            bad++; $display("FAIL abort_restart: done=%b diff at %0d, got %0d writes, required %0d", ok, d, got_addr.size(), exp_addr.size());
        end
    endtask

    task automatic test_len0_and_async_reset();
        clear_log();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL len0_pre: got done=%b, required 0", done);
        end
        arm_cmd(23'h500, 23'd0);
        total++;
        if (done !== 1'b1 || capturing !== 1'b0) begin
            bad++; $display("FAIL len0_done: got done=%b cap=%b, required 1/0", done, capturing);
        end
        repeat (4) tick();
        total++;
        if (got_addr.size() != 0) begin
            bad++; $display("FAIL len0_no_write: got %0d writes, required 0", got_addr.size());
        end
        busy = 1'b1;
        arm_cmd(23'h600, 23'd4);
        vsync_pulse();
        send_pixel(24'hA5A5A5);
        total++;
        if (capturing !== 1'b1) begin
            bad++; $display("FAIL areset_pre: got cap=%b, required 1", capturing);
        end
        @(negedge clk);
        #2;
        busy  = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({mem_if.in_valid, mem_if.rw, mem_if.addr, mem_if.data_in, capturing, done, drop_cnt, leds} !== 72'd0) begin
            bad++; $display("FAIL areset_outputs: got valid=%b addr=%h data=%h cap=%b done=%b leds=%b, required all 0",
                            mem_if.in_valid, mem_if.addr, mem_if.data_in, capturing, done, leds);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] base;
        logic [23:0] pix;
        int len, extra, d;
        bit ok;
        for (int round = 0; round < 5; round++) begin
            clear_log();
            base  = ADDR_W'($urandom);
            len   = $urandom_range(1, 6);
            extra = $urandom_range(0, 2);
            rand_busy = 1'b1;
            arm_cmd(base, ADDR_W'(len));
            vsync_pulse();
            for (int i = 0; i < len + extra; i++) begin
                pix = 24'($urandom);
                if (i < len) expect_write(base, i, pix);
                send_pixel(pix);
            end
            rand_busy = 1'b0;
            busy = 1'b0;
            wait_done(ok);
            repeat (3) tick();
            d = first_diff();
            total++;
            if (!ok || d != -1 || drop_cnt !== 8'd0) begin
                bad++; $display("FAIL random_round%0d: done=%b diff at %0d, got %0d writes drop=%0d, required %0d writes drop=0",
                                round, ok, d, got_addr.size(), drop_cnt, exp_addr.size());
            end
        end
    endtask

    task automatic test_bus_rules();
        total++;
        if (idle_bad != 0 || rw_bad != 0) begin
            bad++; $display("FAIL bus_rules: got idle-nonzero=%0d rw-differs=%0d, required 0/0", idle_bad, rw_bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_vsync();
        test_busy_stall();
        test_wrap();
        test_abort();
        test_len0_and_async_reset();
        test_random();
        test_bus_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tvp_frame_sampler.md
Name: tvp_frame_sampler

Overview:
Parametrised successor to the single-word TVP pixel sampler. Synchronises the TVP pixel clock and VSYNC into the system clock domain and captures a programmable number of RGB pixels, starting at the first VSYNC rising edge after arming. Pixels pass through a small FIFO that absorbs memory-controller busy stalls, then are written to SDRAM from a programmable base address. Status flags and a drop counter replace the single free-running error nibble.

Parameters:
COLOR_W, 8, bits per colour channel.
ADDR_W, 23, memory word-address width.
DATA_W, 32, memory data width; must satisfy 3*COLOR_W <= DATA_W.
FIFO_AW, 3, log2 of FIFO depth (default depth 8).

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
r  in  COLOR_W  red, from the TVP.
g  in  COLOR_W  green.
b  in  COLOR_W  blue.
sample_clock  in  1  TVP pixel clock (asynchronous).
vsync  in  1  TVP vertical sync (asynchronous, active-high).
arm  in  1  single-cycle start pulse.
abort  in  1  single-cycle cancel pulse.
base_addr  in  ADDR_W  first write address; latched on arm.
length  in  ADDR_W  pixels to capture; latched on arm.
addr  out  ADDR_W  memory write address.
rw  out  1  1 = write.
data_in  out  DATA_W  write data: {r,g,b}, MSB-aligned, zero-padded at the LSB end.
busy  in  1  memory controller busy.
in_valid  out  1  write request strobe.
capturing  out  1  high in WAIT_VSYNC or CAPTURE.
done  out  1  high in DONE.
drop_cnt  out  8  saturating count of dropped pixels.
leds  out  4  {drop_cnt!=0, done, state==CAPTURE, state==WAIT_VSYNC}.

Behaviour:
- Reset (async assert, sync release): state IDLE, FIFO empty, counters 0, synchronisers 0. All outputs 0.
- Synchronisers: sample_clock and vsync each pass through 2 flops plus 1 history flop. Edge = sync & ~hist. Capture latency from pin edge is 3 clk. Pixel data is sampled directly at the edge-detect cycle.
- States: IDLE, WAIT_VSYNC, CAPTURE, DRAIN, DONE.
- IDLE or DONE, arm: latch base_addr and length; clear the accepted count, write index and drop_cnt.
  - length = 0 goes directly to DONE.
  - Otherwise go to WAIT_VSYNC.
- arm in any other state is ignored.
- WAIT_VSYNC, vsync edge: go to CAPTURE. A sample edge in the same cycle is not captured.
- CAPTURE, sample edge:
  - If the FIFO is not full, or a pop occurs in the same cycle, push {r,g,b} and increment the accepted count.
  - Otherwise drop the pixel and increment drop_cnt, saturating at 255. Dropped pixels do not count toward length.
- CAPTURE: when accepted == length after a push, go to DRAIN.
- DRAIN: when the FIFO is empty and no pop occurs this cycle, go to DONE.
- abort (priority over arm and all transitions): go to IDLE and flush the FIFO. drop_cnt is kept. in_valid is forced 0 in that cycle.
- Write side, combinational:
  - in_valid = FIFO non-empty & ~busy & ~abort. rw = in_valid.
  - addr = (base + wr_idx) mod 2^ADDR_W; the address wraps silently.
  - data_in = FIFO head.
  - When in_valid is 0, addr and data_in are driven to 0.
- On in_valid, pop the FIFO and increment wr_idx. Zero-latency handshake: a request is accepted in the cycle it is issued.
- Write side operates in every state with a non-empty FIFO. Push and pop on the same cycle are legal, including when the FIFO is full.
- FIFO uses registered storage and FIFO_AW+1-bit pointers; full/empty come from pointer MSB compare.

Test Plan:
1. length=4, base=0x100, busy=0, vsync edge then 6 pixel edges -> writes at 0x100..0x103 with data {r,g,b,8'h00} of pixels 1-4; done=1; drop_cnt=0.
2. Pixel edges before vsync in WAIT_VSYNC -> no writes. A vsync edge coinciding with a pixel edge -> that pixel is not captured.
3. busy held high for 12 pixel edges, depth 8, length=16 -> 8 pixels queued, drop_cnt=4. After busy drops, the remaining writes complete; addresses are contiguous with no gaps; done only after 16 accepted.
4. base=0x7FFFFE, length=4 -> addresses 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001.
5. abort mid-CAPTURE with 3 pixels queued -> in_valid=0 from that cycle; state IDLE; FIFO empty. A subsequent arm restarts capture at base.
6. length=0 arm -> done next cycle, no writes. rst_n asserted mid-CAPTURE -> all outputs 0 immediately, without waiting for a clk edge.
